// File: rtl/ahb3lite_gpio_slave.sv
// AHB3-Lite GPIO responder: DATA_OUT / DATA_IN / DIR / TOGGLE register bank
// with programmable wait states and the two-cycle ERROR response.
module ahb3lite_gpio_slave #(
  parameter int unsigned               g_gpio_width  = 8,
  parameter int unsigned               g_wait_states = 0,
  parameter logic [g_gpio_width-1:0]   g_dout_reset  = '0
) (
  input  logic                    hclk_i,
  input  logic                    hreset_n_i,
  input  logic                    hsel_i,
  input  logic [31:0]             haddr_i,
  input  logic [31:0]             hwdata_i,
  output logic [31:0]             hrdata_o,
  input  logic                    hwrite_i,
  input  logic [2:0]              hsize_i,
  input  logic [2:0]              hburst_i,
  input  logic [3:0]              hprot_i,
  input  logic [1:0]              htrans_i,
  input  logic                    hready_i,
  output logic                    hreadyout_o,
  output logic                    hresp_o,
  input  logic [g_gpio_width-1:0] gpio_i,
  output logic [g_gpio_width-1:0] gpio_o,
  output logic [g_gpio_width-1:0] gpio_oe_o
);

  localparam int unsigned W = g_gpio_width;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [3:0]     addr_q, addr_d;
  logic           write_q, write_d;
  logic [1:0]     size_q, size_d;
  logic [W-1:0]   dout_q, dout_d;
  logic [W-1:0]   dir_q, dir_d;
  logic [W-1:0]   sync1_q, sync2_q;
  logic [31:0]    hrdata_q, hrdata_d;

  logic           accept;
  logic           bad;
  logic           can_accept;
  logic           commit;
  logic [31:0]    wmask;
  logic [W-1:0]   wm;
  logic [W-1:0]   wd;

  // Byte-lane enables for the latched transfer size and address
  function automatic logic [31:0] lanes(input logic [1:0] size, input logic [1:0] a);
    logic [31:0] m;
    case (size)
      2'd0:    m = 32'h0000_00FF << {a, 3'b000};
      2'd1:    m = a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      default: m = '1;
    endcase
    return m;
  endfunction

  // Register read multiplexer; TOGGLE reads as zero, unused bits zero
  function automatic logic [31:0] read_mux(input logic [1:0] reg_sel,
                                           input logic [W-1:0] dout,
                                           input logic [W-1:0] dir,
                                           input logic [W-1:0] din);
    logic [31:0] r;
    r = '0;
    case (reg_sel)
      2'd0:    r[W-1:0] = dout;
      2'd1:    r[W-1:0] = din;
      2'd2:    r[W-1:0] = dir;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign accept = hsel_i && hready_i && htrans_i[1];
  assign bad    = (hsize_i > 3'd2)
               || ((hsize_i == 3'd1) && haddr_i[0])
               || ((hsize_i == 3'd2) && (haddr_i[1:0] != 2'b00))
               || (hwrite_i && (haddr_i[3:2] == 2'b01));
  assign wmask  = lanes(size_q, addr_q[1:0]);
  assign wm     = wmask[W-1:0];
  assign wd     = hwdata_i[W-1:0] & wm;

  logic unused_ok;
  assign unused_ok = ^{hburst_i, hprot_i, htrans_i[0], haddr_i[31:4], hwdata_i, wmask};

  // Next-state, register update and read-data selection.
  // Reads accepted in the same cycle as a committing write sample the
  // post-commit values, giving read-after-write without an extra stall.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    size_d     = size_q;
    dout_d     = dout_q;
    dir_d      = dir_q;
    hrdata_d   = '0;
    can_accept = 1'b0;
    commit     = 1'b0;

    case (state_q)
      ST_IDLE: can_accept = 1'b1;
      ST_DATA: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          if ((cnt_q == 4'd1) && !write_q) begin
            hrdata_d = read_mux(addr_q[3:2], dout_q, dir_q, sync2_q);
          end
        end else begin
          commit     = write_q;
          can_accept = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: begin
        state_d    = ST_IDLE;
        can_accept = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (commit) begin
      case (addr_q[3:2])
        2'd0:    dout_d = (dout_q & ~wm) | wd;
        2'd2:    dir_d  = (dir_q & ~wm) | wd;
        2'd3:    dout_d = dout_q ^ wd;
        default: dout_d = dout_q;
      endcase
    end

    if (can_accept && accept) begin
      addr_d  = haddr_i[3:0];
      write_d = hwrite_i;
      size_d  = hsize_i[1:0];
      if (bad) begin
        state_d = ST_ERR1;
        cnt_d   = '0;
      end else begin
        state_d = ST_DATA;
        cnt_d   = 4'(g_wait_states);
        if ((g_wait_states == 0) && !hwrite_i) begin
          hrdata_d = read_mux(haddr_i[3:2], dout_d, dir_d, sync2_q);
        end
      end
    end
  end

  // Bus response outputs decoded from the current state
  always_comb begin
    hreadyout_o = 1'b1;
    hresp_o     = 1'b0;
    case (state_q)
      ST_DATA: hreadyout_o = (cnt_q == 4'd0);
      ST_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = 1'b1;
      end
      ST_ERR2: hresp_o = 1'b1;
      default: hreadyout_o = 1'b1;
    endcase
  end

  // Transfer state, latched address phase, registers and read data
  always_ff @(posedge hclk_i or negedge hreset_n_i) begin
    if (!hreset_n_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      dout_q   <= g_dout_reset;
      dir_q    <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      dout_q   <= dout_d;
      dir_q    <= dir_d;
      hrdata_q <= hrdata_d;
    end
  end

  // Two-flop synchroniser for the asynchronous pin inputs
  always_ff @(posedge hclk_i or negedge hreset_n_i) begin
    if (!hreset_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_i;
      sync2_q <= sync1_q;
    end
  end

  assign hrdata_o  = hrdata_q;
  assign gpio_o    = dout_q;
  assign gpio_oe_o = dir_q;

endmodule
